axis_master_pipe: RTL and testbench
===================================

AXIS_MASTER_PIPE -- requirements
Module: axis_master_pipe

Interface
REQ-001 SHALL have parameter DSIZE, default 32, tdata width in bits (multiple of 8, >= 8).
REQ-002 SHALL have parameter KSIZE, default DSIZE/8, tkeep width in bits.
REQ-003 SHALL have parameter USIZE, default 1, tuser width in bits (>= 1).
REQ-004 SHALL have ports, clock and reset first:
- clock  in  1  rising-edge clock for all state.
- rst_n  in  1  reset, asynchronous, active-low.
- in_tdata  in  DSIZE  upstream data.
- in_tvalid  in  1  upstream valid.
- in_tready  out  1  upstream ready, driven directly from a flop.
- in_tlast  in  1  upstream end of packet.
- in_tkeep  in  KSIZE  upstream byte enables.
- in_tuser  in  USIZE  upstream sideband.
- out_tdata  out  DSIZE  downstream data, registered.
- out_tvalid  out  1  downstream valid, registered.
- out_tready  in  1  downstream ready.
- out_tlast  out  1  downstream end of packet, registered.
- out_tkeep  out  KSIZE  downstream byte enables, registered.
- out_tuser  out  USIZE  downstream sideband, registered.
- occupancy  out  2  beats held (0..2), registered.

Function
REQ-005 SHALL have no combinational path between any in_* and any out_* port, in either direction; every output SHALL come straight from a flop.
REQ-006 SHALL hold a beat as {tdata, tlast, tkeep, tuser}, and SHALL store beats in a head register (drives out_*) and a skid register.
REQ-007 SHALL define in_fire = in_tvalid & in_tready, and out_fire = out_tvalid & out_tready.
REQ-008 SHALL implement states EMPTY (occupancy 0), ONE (1) and FULL (2).
REQ-009 SHALL drive out_tvalid = 1 in ONE and FULL, and 0 in EMPTY.
REQ-010 SHALL drive in_tready = 1 in EMPTY and ONE, and 0 in FULL.
REQ-011 In EMPTY, on in_fire: SHALL load the head from the input and go to ONE; otherwise SHALL stay in EMPTY.
REQ-012 In ONE, SHALL act on the four cases of in_fire and out_fire:
- in_fire and not out_fire: load skid, go to FULL.
- out_fire and not in_fire: go to EMPTY.
- in_fire and out_fire together: load head from the input, stay in ONE.
- neither: hold.
REQ-013 In FULL, on out_fire: SHALL copy skid to head and go to ONE; otherwise SHALL hold. No input is accepted in FULL.
REQ-014 On entering EMPTY, SHALL clear the head to idle values: tdata 0, tlast 0, tkeep all ones, tuser 0.
REQ-015 SHALL hold head contents stable while out_tvalid=1 and out_tready=0.
REQ-016 SHALL preserve beat order, with no loss and no duplication.
REQ-017 SHALL have 1-cycle latency from in_fire in EMPTY to out_tvalid=1.
REQ-018 SHALL sustain 1 beat per cycle while out_tready stays high.
REQ-019 SHALL add no stall bubble when out_tready drops for one cycle during streaming.
REQ-020 SHALL pass tlast, tkeep and tuser with their beat, unmodified.
REQ-021 SHALL flag as a simulation error, at elaboration, KSIZE != DSIZE/8.

Reset
REQ-022 While rst_n=0, SHALL force state EMPTY, occupancy 0, out_tvalid 0 and in_tready 1.
REQ-023 While rst_n=0, SHALL force head and skid to idle values: tdata 0, tlast 0, tkeep all ones, tuser 0.
REQ-024 Reset asserted mid-transfer SHALL discard held beats immediately, without waiting for a clock edge.
REQ-025 After rst_n rises, SHALL accept on the first clock edge.

Verification
REQ-026 Bench SHALL cover: out_tready=1, beats 0x11,0x22,0x33 on consecutive cycles -> out_tdata 0x11,0x22,0x33 on the next three cycles, occupancy 1 throughout, in_tready=1 throughout.
REQ-027 Bench SHALL cover: out_tready=0, push 0xA1 then 0xA2 -> occupancy 2, in_tready=0, out_tdata=0xA1 held; raise out_tready -> 0xA1 then 0xA2 out, then out_tvalid=0 and out_tdata=0.
REQ-028 Bench SHALL cover: streaming with out_tready low for one cycle -> order kept, no lost beat, in_tready drops for at most one cycle.
REQ-029 Bench SHALL cover: 4-beat packet with tlast on beat 4, tkeep=0x3 on beat 4, tuser=1 on beat 1 -> identical sidebands on the output beats.
REQ-030 Bench SHALL cover: rst_n pulled low while FULL -> at once out_tvalid=0, occupancy 0, in_tready=1, out_tkeep=all ones; next beat after release passes with 1-cycle latency.
REQ-031 Bench SHALL cover: random tvalid/tready at 50% each over 10000 beats, compared against a reference FIFO model -> zero mismatches, and occupancy never above 2.

Source files
------------

// File: rtl/axis_master_pipe.sv
// Two-entry AXI-Stream register slice: head register drives the outputs, skid
// register absorbs the one beat in flight when the sink stalls.
module axis_master_pipe #(
    parameter int DSIZE = 32,
    parameter int KSIZE = DSIZE / 8,
    parameter int USIZE = 1
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic [DSIZE-1:0] in_tdata,
    input  logic             in_tvalid,
    output logic             in_tready,
    input  logic             in_tlast,
    input  logic [KSIZE-1:0] in_tkeep,
    input  logic [USIZE-1:0] in_tuser,
    output logic [DSIZE-1:0] out_tdata,
    output logic             out_tvalid,
    input  logic             out_tready,
    output logic             out_tlast,
    output logic [KSIZE-1:0] out_tkeep,
    output logic [USIZE-1:0] out_tuser,
    output logic [1:0]       occupancy
);

    if (KSIZE != DSIZE / 8) begin : g_bad_ksize
        $error("axis_master_pipe: KSIZE (%0d) must equal DSIZE/8 (%0d)", KSIZE, DSIZE / 8);
    end

    typedef struct packed {
        logic [DSIZE-1:0] tdata;
        logic             tlast;
        logic [KSIZE-1:0] tkeep;
        logic [USIZE-1:0] tuser;
    } beat_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam beat_t IDLE = beat_t'({{DSIZE{1'b0}}, 1'b0, {KSIZE{1'b1}}, {USIZE{1'b0}}});

    state_t state;
    beat_t  head;
    beat_t  skid;
    beat_t  in_beat;
    logic   in_fire;
    logic   out_fire;

    assign in_beat  = '{tdata: in_tdata, tlast: in_tlast, tkeep: in_tkeep, tuser: in_tuser};
    assign in_fire  = in_tvalid & in_tready;
    assign out_fire = out_tvalid & out_tready;

    // in_tready, out_tvalid and occupancy are flops updated alongside the
    // state so no input ever reaches an output combinationally.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            head       <= IDLE;
            skid       <= IDLE;
            out_tvalid <= 1'b0;
            in_tready  <= 1'b1;
            occupancy  <= 2'd0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        head       <= in_beat;
                        state      <= ONE;
                        out_tvalid <= 1'b1;
                        occupancy  <= 2'd1;
                    end
                end
                ONE: begin
                    if (in_fire && !out_fire) begin
                        skid      <= in_beat;
                        state     <= FULL;
                        in_tready <= 1'b0;
                        occupancy <= 2'd2;
                    end else if (out_fire && !in_fire) begin
                        head       <= IDLE;
                        state      <= EMPTY;
                        out_tvalid <= 1'b0;
                        occupancy  <= 2'd0;
                    end else if (in_fire && out_fire) begin
                        head <= in_beat;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        head      <= skid;
                        state     <= ONE;
                        in_tready <= 1'b1;
                        occupancy <= 2'd1;
                    end
                end
                default: begin
                    state      <= EMPTY;
                    head       <= IDLE;
                    skid       <= IDLE;
                    out_tvalid <= 1'b0;
                    in_tready  <= 1'b1;
                    occupancy  <= 2'd0;
                end
            endcase
        end
    end

    assign out_tdata = head.tdata;
    assign out_tlast = head.tlast;
    assign out_tkeep = head.tkeep;
    assign out_tuser = head.tuser;

endmodule

// File: tb/tb_axis_master_pipe.sv
// Bench for axis_master_pipe: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then a long random run.
module tb_axis_master_pipe;

    localparam int DSIZE = 32;
    localparam int KSIZE = 4;
    localparam int USIZE = 1;
    localparam int BW    = DSIZE + 1 + KSIZE + USIZE;
    localparam logic [BW-1:0] IDLE_BEAT = {32'h0, 1'b0, 4'hF, 1'b0};

    logic             clock = 1'b0;
    logic             rst_n = 1'b1;
    logic [DSIZE-1:0] in_tdata = '0;
    logic             in_tvalid = 1'b0;
    logic             in_tready;
    logic             in_tlast = 1'b0;
    logic [KSIZE-1:0] in_tkeep = 4'hF;
    logic [USIZE-1:0] in_tuser = '0;
    logic [DSIZE-1:0] out_tdata;
    logic             out_tvalid;
    logic             out_tready = 1'b0;
    logic             out_tlast;
    logic [KSIZE-1:0] out_tkeep;
    logic [USIZE-1:0] out_tuser;
    logic [1:0]       occupancy;

    axis_master_pipe #(.DSIZE(DSIZE), .KSIZE(KSIZE), .USIZE(USIZE)) dut (
        .clock(clock), .rst_n(rst_n),
        .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tready(in_tready),
        .in_tlast(in_tlast), .in_tkeep(in_tkeep), .in_tuser(in_tuser),
        .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tready(out_tready),
        .out_tlast(out_tlast), .out_tkeep(out_tkeep), .out_tuser(out_tuser),
        .occupancy(occupancy)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] out_beat();
        return {out_tdata, out_tlast, out_tkeep, out_tuser};
    endfunction

    // Reference model: the slice is a FIFO of depth two with registered flags.
    logic [BW-1:0] q[$];
    bit m_in_fire, m_out_fire;

    always @(negedge rst_n) q.delete();

    always @(posedge clock) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            m_in_fire  = in_tvalid && (q.size() < 2);
            m_out_fire = (q.size() > 0) && out_tready;
            if (m_out_fire) void'(q.pop_front());
            if (m_in_fire) q.push_back({in_tdata, in_tlast, in_tkeep, in_tuser});
        end
    end

    always @(negedge clock) begin
        if (chk_on) begin
            chk("model_occ", 64'(occupancy), 64'(q.size()));
            chk("model_vld_rdy", {62'd0, out_tvalid, in_tready},
                {62'd0, q.size() > 0, q.size() < 2});
            chk("model_beat", 64'(out_beat()), 64'(q.size() > 0 ? q[0] : IDLE_BEAT));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic put(input logic v, input logic [31:0] d, input logic l,
                       input logic [3:0] k, input logic u);
        in_tvalid = v;
        in_tdata  = d;
        in_tlast  = l;
        in_tkeep  = k;
        in_tuser  = u;
    endtask

    int k, cyc, lowrun, maxlow, outs, acc, maxocc;
    logic [31:0] exp26[3];
    logic [BW-1:0] exp29[4];

    initial begin
        #1 rst_n = 1'b0;
        #1 chk_on = 1'b1;
        tick();
        #3;
        chk("reset_state", {out_tvalid, in_tready, occupancy}, {1'b0, 1'b1, 2'd0});
        chk("reset_head", 64'(out_beat()), 64'(IDLE_BEAT));
        tick();
        rst_n = 1'b1;

        // Back-to-back stream, sink always ready.
        out_tready = 1'b1;
        exp26 = '{32'h11, 32'h22, 32'h33};
        for (int i = 0; i < 3; i++) begin
            put(1'b1, exp26[i], 1'b0, 4'hF, 1'b0);
            tick();
            if (i == 2) in_tvalid = 1'b0;
            @(negedge clock);
            chk("stream_data", 64'(out_tdata), 64'(exp26[i]));
            chk("stream_flags", {out_tvalid, in_tready, occupancy}, {1'b1, 1'b1, 2'd1});
        end
        tick();

        // Fill both registers while stalled, then drain.
        out_tready = 1'b0;
        put(1'b1, 32'hA1, 1'b0, 4'hF, 1'b0);
        tick();
        in_tdata = 32'hA2;
        tick();
        in_tvalid = 1'b0;
        @(negedge clock);
        chk("full_flags", {out_tvalid, in_tready, occupancy}, {1'b1, 1'b0, 2'd2});
        chk("full_head", 64'(out_tdata), 64'hA1);
        tick();
        out_tready = 1'b1;
        @(negedge clock);
        chk("full_hold", 64'(out_tdata), 64'hA1);
        tick();
        @(negedge clock);
        chk("drain_a2", {out_tdata, occupancy}, {32'hA2, 2'd1});
        tick();
        @(negedge clock);
        chk("drain_empty", {out_tdata, out_tvalid, occupancy}, {32'h0, 1'b0, 2'd0});
        tick();

        // Streaming with a single-cycle sink stall.
        k = 0; cyc = 0; lowrun = 0; maxlow = 0; outs = 0;
        while (k < 8 && cyc < 50) begin
            put(1'b1, 32'h50 + k, 1'b0, 4'hF, 1'b0);
            out_tready = (cyc != 3);
            @(negedge clock);
            lowrun = in_tready ? 0 : lowrun + 1;
            if (lowrun > maxlow) maxlow = lowrun;
            acc = in_tready;
            if (out_tvalid && out_tready) outs++;
            tick();
            if (acc != 0) k++;
            cyc++;
        end
        in_tvalid = 1'b0;
        out_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (out_tvalid && out_tready) outs++;
            tick();
        end
        chk("stall_sent", 64'(k), 64'd8);
        chk("stall_ready_low", 64'(maxlow), 64'd1);
        chk("stall_outs", 64'(outs), 64'd8);

        // Packet with sidebands.
        exp29 = '{{32'hB0, 1'b0, 4'hF, 1'b1}, {32'hB1, 1'b0, 4'hF, 1'b0},
                  {32'hB2, 1'b0, 4'hF, 1'b0}, {32'hB3, 1'b1, 4'h3, 1'b0}};
        for (int i = 0; i < 4; i++) begin
            {in_tdata, in_tlast, in_tkeep, in_tuser} = exp29[i];
            in_tvalid = 1'b1;
            tick();
            if (i == 3) in_tvalid = 1'b0;
            @(negedge clock);
            chk("pkt_beat", 64'(out_beat()), 64'(exp29[i]));
        end
        put(1'b0, 32'h0, 1'b0, 4'hF, 1'b0);
        tick();

        // Asynchronous reset while full.
        out_tready = 1'b0;
        put(1'b1, 32'hC1, 1'b0, 4'h1, 1'b1);
        tick();
        in_tdata = 32'hC2;
        tick();
        in_tvalid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst", {out_tvalid, occupancy, in_tready, out_tkeep},
            {1'b0, 2'd0, 1'b1, 4'hF});
        tick();
        rst_n = 1'b1;
        out_tready = 1'b1;
        put(1'b1, 32'h77, 1'b1, 4'h7, 1'b0);
        tick();
        in_tvalid = 1'b0;
        @(negedge clock);
        chk("post_rst_beat", {out_tvalid, out_tdata}, {1'b1, 32'h77});
        tick();

        // Random valid/ready at 50% for 10000 accepted beats.
        acc = 0; cyc = 0; maxocc = 0;
        while (acc < 10000 && cyc < 40000) begin
            put($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 1) == 1,
                4'($urandom), $urandom_range(0, 1) == 1);
            out_tready = $urandom_range(0, 1) == 1;
            @(negedge clock);
            if (in_tvalid && in_tready) acc++;
            if (32'(occupancy) > maxocc) maxocc = occupancy;
            tick();
            cyc++;
        end
        in_tvalid = 1'b0;
        out_tready = 1'b1;
        tick(); tick(); tick();
        chk("rand_accepted", 64'(acc), 64'd10000);
        chk("rand_occ_max", 64'(maxocc <= 2), 64'd1);
        @(negedge clock);
        chk("rand_drained", {out_tvalid, occupancy}, {1'b0, 2'd0});

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
